mul32_seq: RTL and testbench
============================

# mul32_seq

Iterative 32×32→64 multiplier for the EX stage of the pipelined CPU, serving MULT/MULTU into HI/LO. Each cycle it drives one cla32 instance with the running partial product and the multiplicand, and shifts the sum and carry-out back into its accumulator. It raises `busy` to stall the pipeline while running. It pulses `done` when the 64-bit result is registered on `hi`/`lo`.

## Interface
Parameters:
- none (width fixed at 32; iteration count fixed at 32)

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `sign`  in  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with `start`
- `a`  in  32  multiplicand; sampled with `start`
- `b`  in  32  multiplier; sampled with `start`
- `busy`  out  1  high whenever state ≠ IDLE; drives the pipeline stall
- `done`  out  1  one-cycle pulse; result valid
- `hi`  out  32  result bits [63:32]; registered
- `lo`  out  32  result bits [31:0]; registered

## Operation
- States: IDLE, LOAD, RUN, FIX.
- IDLE:
  - `start`=1 captures `a`, `b`, `sign`; next state LOAD.
  - `start`=0: stay in IDLE.
- LOAD:
  - mcand ← |a| and mplr ← |b| if signed, else raw operands.
  - neg ← sign & (a[31]^b[31]).
  - acc_hi ← 0; acc_lo ← mplr; cnt ← 0.
  - Next state RUN.
- RUN, one step per cycle:
  - cla32 gets a = acc_hi, b = (acc_lo[0] ? mcand : 0), ci = 0.
  - {acc_hi, acc_lo} ← {co, s, acc_lo} >> 1, a 65-bit shift that drops the LSB.
  - cnt increments. After the step with cnt = 31, next state is FIX.
  - cnt is 5 bits and must never wrap within an operation.
- FIX:
  - If neg, {hi, lo} ← two's complement of {acc_hi, acc_lo}; else {hi, lo} ← {acc_hi, acc_lo}.
  - `done` is registered to 1 for the next cycle.
  - Next state IDLE.
- `hi`/`lo` update only on the FIX edge. They hold their value until the next FIX, or until reset.
- `start` while `busy`=1 is ignored and not queued. `a`/`b`/`sign` may change freely after capture.
- `start`=1 in the same cycle `done`=1 (state is IDLE) is accepted. `hi`/`lo` keep the previous result until the new FIX.
- `rst`=1 in any state, including mid-RUN, takes effect on the next edge:
  - state → IDLE.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0, cnt=0.
  - The partial operation is abandoned.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=32'h0, `lo`=32'h0.
- Call the edge that samples `start` in IDLE edge 0.
- Edge 0 → LOAD (`busy`=1 from cycle 1).
- Edges 1–32 → RUN.
- Edge 33 → FIX.
- Edge 34 → IDLE with `done`=1 and `hi`/`lo` valid in cycle 35.
- Fixed latency: 35 cycles from start sample to `done`, independent of operand values and `sign`. There is no early termination.
- `busy` is high for exactly 34 cycles per operation.
- Back-to-back throughput: one result per 35 cycles.

## Configuration
- `MUL_SIGNED_EN` defined:
  - `sign` is honoured: absolute values are taken in LOAD and the result is negated in FIX when the operand signs differ.
- `MUL_SIGNED_EN` undefined:
  - `sign` is ignored and every operation is unsigned.
  - No abs/negate logic is built.
  - FIX still occupies one cycle, so latency stays 35.

## Test plan
- Reset, then `a`=3, `b`=5, `sign`=0, `start` for one cycle → `busy` high cycles 1–34; `done`=1 in cycle 35 only; `hi`=0, `lo`=15.
- `a`=`b`=32'hFFFFFFFF, `sign`=0 → `hi`=32'hFFFFFFFE, `lo`=32'h00000001, which checks carry-out propagation into acc_hi.
- With `MUL_SIGNED_EN`:
  - `a`=32'hFFFFFFFF, `b`=32'hFFFFFFFF, `sign`=1 → `hi`=0, `lo`=1.
  - `a`=32'hFFFFFFFE (−2), `b`=3, `sign`=1 → `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFFA.
  - `a`=32'h80000000, `b`=32'h80000000, `sign`=1 → `hi`=32'h40000000, `lo`=0.
- Start 7×9, pulse `start` with 2×2 at cycle 10 → ignored; `done` at cycle 35 with `lo`=63. A new `start` in that same cycle (2×2) → `done` 35 cycles later with `lo`=4; `lo` reads 63 in between.
- Start 7×9, assert `rst` at cycle 12 → the next cycle has `busy`=0, `hi`=`lo`=0, and `done` never pulses. A following `start` with 4×4 → `lo`=16 at the normal latency.

Source files
------------

// File: rtl/mul32_seq.sv
// Iterative 32x32->64 multiplier (MULT/MULTU into HI/LO), one cla32 add-and-shift step per cycle.
// Optional signed support is built only when MUL_SIGNED_EN is defined.

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [31:0] g_s;
  logic [31:0] p_s;
  logic [31:0] c_s;
  logic [7:0]  gg_s;
  logic [7:0]  gp_s;
  logic [8:0]  gc_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // 4-bit group generate/propagate terms
  always_comb begin
    gg_s = 8'd0;
    gp_s = 8'd0;
    for (int k = 0; k < 8; k++) begin
      gg_s[k] = g_s[4*k+3]
              | (p_s[4*k+3] & g_s[4*k+2])
              | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
              | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
      gp_s[k] = &p_s[4*k +: 4];
    end
  end

  // group-level carry chain, then per-bit lookahead inside each group
  always_comb begin
    logic carry;
    gc_s  = 9'd0;
    c_s   = 32'd0;
    carry = ci;
    for (int k = 0; k < 8; k++) begin
      gc_s[k] = carry;
      carry   = gg_s[k] | (gp_s[k] & carry);
    end
    gc_s[8] = carry;
    for (int k = 0; k < 8; k++) begin
      c_s[4*k]   = gc_s[k];
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
      c_s[4*k+2] = g_s[4*k+1]
                 | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
      c_s[4*k+3] = g_s[4*k+2]
                 | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
    end
  end

  assign s  = p_s ^ c_s;
  assign co = gc_s[8];

endmodule

module mul32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [31:0] cla_b_s;
  logic [31:0] cla_sum_s;
  logic        cla_co_s;

`ifdef MUL_SIGNED_EN
  logic        sign_q, sign_d;
  logic        neg_q, neg_d;
`else
  logic        sign_unused;
  assign sign_unused = sign;
`endif

  assign cla_b_s = acc_lo_q[0] ? mcand_q : 32'd0;

  cla32 u_cla (
    .a  (acc_hi_q),
    .b  (cla_b_s),
    .ci (1'b0),
    .s  (cla_sum_s),
    .co (cla_co_s)
  );

  // next-state and datapath update for the IDLE/LOAD/RUN/FIX sequence
  always_comb begin
    logic [63:0] prod_v;
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    prod_v   = {acc_hi_q, acc_lo_q};
`ifdef MUL_SIGNED_EN
    sign_d   = sign_q;
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
`ifdef MUL_SIGNED_EN
          sign_d  = sign;
`endif
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
`ifdef MUL_SIGNED_EN
        if (sign_q && a_q[31]) begin
          mcand_d = ~a_q + 32'd1;
        end else begin
          mcand_d = a_q;
        end
        if (sign_q && b_q[31]) begin
          acc_lo_d = ~b_q + 32'd1;
        end else begin
          acc_lo_d = b_q;
        end
        neg_d = sign_q & (a_q[31] ^ b_q[31]);
`else
        mcand_d  = a_q;
        acc_lo_d = b_q;
`endif
        acc_hi_d = 32'd0;
        cnt_d    = 5'd0;
        state_d  = RUN;
      end
      RUN: begin
        {acc_hi_d, acc_lo_d} = {cla_co_s, cla_sum_s, acc_lo_q[31:1]};
        // cnt holds at 31 on the last step so it never wraps
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          state_d = RUN;
        end
      end
      FIX: begin
`ifdef MUL_SIGNED_EN
        if (neg_q) begin
          prod_v = ~{acc_hi_q, acc_lo_q} + 64'd1;
        end else begin
          prod_v = {acc_hi_q, acc_lo_q};
        end
`endif
        hi_d    = prod_v[63:32];
        lo_d    = prod_v[31:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      mcand_q  <= 32'd0;
      acc_hi_q <= 32'd0;
      acc_lo_q <= 32'd0;
      cnt_q    <= 5'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MUL_SIGNED_EN
      sign_q   <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef MUL_SIGNED_EN
      sign_q   <= sign_d;
      neg_q    <= neg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq: cycle-level behavioural model plus directed literal checks.
// Signed vectors are included only when MUL_SIGNED_EN is defined.

module tb_mul32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int vec_cnt = 0;
  int miss_cnt = 0;
  bit chk_en = 1'b0;

  mul32_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sign  (sign),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [63:0] xe, ye;
    xe = {32'd0, x};
    ye = {32'd0, y};
`ifdef MUL_SIGNED_EN
    if (s) begin
      xe = {{32{x[31]}}, x};
      ye = {{32{y[31]}}, y};
    end
`endif
    return xe * ye;
  endfunction

  // Model: an accepted op is busy for 34 cycles, then result and done appear together.
  int          m_t = 0;
  logic [63:0] m_pend = 64'd0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic        m_done = 1'b0;
  logic        m_busy = 1'b0;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) begin
      m_t    <= 0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_busy <= 1'b0;
    end else if (m_t == 0) begin
      if (start) begin
        m_t    <= 1;
        m_pend <= prod(a, b, sign);
        m_busy <= 1'b1;
      end
    end else if (m_t == 34) begin
      m_t    <= 0;
      m_hi   <= m_pend[63:32];
      m_lo   <= m_pend[31:0];
      m_done <= 1'b1;
      m_busy <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      vec_cnt++;
      if (busy !== m_busy || done !== m_done || hi !== m_hi || lo !== m_lo) begin
        miss_cnt++;
        $display("FAIL cycle t=%0t: busy %b/%b done %b/%b hi %h/%h lo %h/%h (got/expected)",
                 $time, busy, m_busy, done, m_done, hi, m_hi, lo, m_lo);
      end
    end
  endtask

  task automatic pulse_start(input logic [31:0] x, input logic [31:0] y, input logic s);
    start = 1'b1;
    a = x;
    b = y;
    sign = s;
    tick();
    start = 1'b0;
    a = ~x;
    b = ~y;
    sign = ~s;
  endtask

  // Launch one op, wait for done (bounded), check latency, busy length and result literals.
  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n, bc;
    pulse_start(x, y, s);
    n = 1;
    bc = 0;
    while (done !== 1'b1 && n < 60) begin
      if (busy === 1'b1) bc++;
      tick();
      n++;
    end
    chk({name, " latency"}, 64'(n), 64'd35);
    chk({name, " busy cycles"}, 64'(bc), 64'd34);
    chk({name, " hi"}, {32'd0, hi}, {32'd0, ehi});
    chk({name, " lo"}, {32'd0, lo}, {32'd0, elo});
  endtask

  initial begin
    int n, dc;
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset hi/lo", {hi, lo}, 64'd0);
    chk("model 3x5", prod(32'd3, 32'd5, 1'b0), 64'd15);

    run_op("3x5", 32'd3, 32'd5, 1'b0, 32'h0, 32'd15);
    run_op("ffxff u", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    run_op("8000x2", 32'h80000000, 32'd2, 1'b0, 32'h1, 32'h0);
    run_op("0xff", 32'h0, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0);
    run_op("10000sq", 32'h00010000, 32'h00010000, 1'b0, 32'h1, 32'h0);
    run_op("ffx2", 32'hFFFFFFFF, 32'd2, 1'b0, 32'h1, 32'hFFFFFFFE);
`ifdef MUL_SIGNED_EN
    run_op("ffxff s", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h1);
    run_op("-2x3 s", 32'hFFFFFFFE, 32'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("min sq s", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0);
`else
    run_op("sign ignored", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
`endif

    // start while busy is ignored; start in the done cycle is accepted
    pulse_start(32'd7, 32'd9, 1'b0);
    n = 1;
    while (n < 9) begin
      tick();
      n++;
    end
    pulse_start(32'd2, 32'd2, 1'b0);
    n++;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("7x9 latency w/ ignored start", 64'(n), 64'd35);
    chk("7x9 lo", {32'd0, lo}, 64'd63);
    pulse_start(32'd2, 32'd2, 1'b0);
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      if (n == 20) chk("lo holds 63", {32'd0, lo}, 64'd63);
      tick();
      n++;
    end
    chk("2x2 back-to-back latency", 64'(n), 64'd35);
    chk("2x2 lo", {32'd0, lo}, 64'd4);

    // reset mid-RUN abandons the operation
    pulse_start(32'd7, 32'd9, 1'b0);
    n = 1;
    while (n < 12) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid-run reset busy", {63'd0, busy}, 64'd0);
    chk("mid-run reset hi/lo", {hi, lo}, 64'd0);
    dc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) dc++;
    end
    chk("no done after reset", 64'(dc), 64'd0);
    run_op("4x4 after reset", 32'd4, 32'd4, 1'b0, 32'h0, 32'd16);

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
